// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One transaction in flight: accept in IDLE, one EXEC cycle, then hold the response in RESP.
module alu_arbiter #(
    parameter bit BAD_OP_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 3;
    localparam logic [OW-1:0] OP_MAX = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic [OW-1:0]   op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic            busy_q, busy_d;

    logic            req_any_c;
    logic            gnt_id_c;
    logic            accept_c;
    logic            rsp_hs_c;
    logic            bad_op_c;

    // Round-robin pick: a lone requester wins, a tie goes away from last_grant.
    always_comb begin
        req_any_c = req0_valid | req1_valid;
        gnt_id_c  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        accept_c  = (state_q == IDLE) & req_any_c;
        rsp_hs_c  = (state_q == RESP) &
                    (grant_q ? (rsp1_valid_q & rsp1_ready) : (rsp0_valid_q & rsp0_ready));
        bad_op_c  = BAD_OP_ERR & (op_q > OP_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready   = accept_c & ~gnt_id_c;
        req1_ready   = accept_c & gnt_id_c;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    grant_d = gnt_id_c;
                    op_d    = gnt_id_c ? req1_op : req0_op;
                    a_d     = gnt_id_c ? req1_a  : req0_a;
                    b_d     = gnt_id_c ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                result_d = bad_op_c ? '0 : alu_result;
                err_d    = bad_op_c;
            end
            RESP: begin
                // Valid rises one cycle into RESP and drops on the handshake edge.
                rsp0_valid_d = ~grant_q & ~rsp_hs_c;
                rsp1_valid_d = grant_q & ~rsp_hs_c;
                if (rsp_hs_c) last_grant_d = grant_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset abort sequence, then random
// transactions predicted by a transaction-level arbitration/ALU model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.BAD_OP_ERR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    // External ALU; illegal opcodes yield junk so the error path is observable.
    function automatic logic [15:0] ext_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return 16'((32'(a) * 32'(b)) & 32'hFFFF);
            3'd3:    return b >> 1;
            3'd4:    return b << 1;
            default: return a ^ b ^ 16'hA5A5;
        endcase
    endfunction

    assign alu_result = ext_alu(alu_op, alu_a, alu_b);

    // Expected response from opcode rules with plain arithmetic.
    function automatic logic [16:0] model_rsp(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int unsigned r;
        if (op > 3'd4) return {1'b1, 16'h0000};
        case (op)
            3'd0:    r = (int'(a) + int'(b)) % 65536;
            3'd1:    r = (65536 + int'(a) - int'(b)) % 65536;
            3'd2:    r = (int'(a) * int'(b)) % 65536;
            3'd3:    r = int'(b) / 2;
            default: r = (int'(b) * 2) % 65536;
        endcase
        return {1'b0, 16'(r)};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction starting at a negedge in IDLE; ends at the negedge after handshake.
    task automatic txn(input string tag, input bit v0, input bit v1,
                       input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                       input int delay, input bit drop,
                       input bit exp_g, input logic [15:0] exp_r, input bit exp_e);
        logic [2:0]  gop;
        logic [15:0] ga, gb;
        gop = exp_g ? op1 : op0;
        ga  = exp_g ? a1 : a0;
        gb  = exp_g ? b1 : b0;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp0_ready = (delay == 0);
        rsp1_ready = (delay == 0);
        #1;
        check1({tag, " req0_ready@grant"}, req0_ready, !exp_g);
        check1({tag, " req1_ready@grant"}, req1_ready, exp_g);
        step();
        if (drop) begin
            if (exp_g) req1_valid = 1'b0;
            else       req0_valid = 1'b0;
        end
        #1;
        check1({tag, " busy@exec"}, busy, 1'b1);
        check1({tag, " ready@exec"}, req0_ready | req1_ready, 1'b0);
        check16({tag, " alu_op@exec"}, 16'(alu_op), 16'(gop));
        check16({tag, " alu_a@exec"}, alu_a, ga);
        check16({tag, " alu_b@exec"}, alu_b, gb);
        step();
        check1({tag, " rsp_valid@T+1"}, rsp0_valid | rsp1_valid, 1'b0);
        step();
        for (int k = 0; k <= delay; k++) begin
            if (k == delay) begin
                rsp0_ready = 1'b1;
                rsp1_ready = 1'b1;
                #1;
            end
            check1({tag, " rsp0_valid"}, rsp0_valid, !exp_g);
            check1({tag, " rsp1_valid"}, rsp1_valid, exp_g);
            check16({tag, " rsp_result"}, rsp_result, exp_r);
            check1({tag, " rsp_err"}, rsp_err, exp_e);
            check1({tag, " busy@resp"}, busy, 1'b1);
            check1({tag, " ready@resp"}, req0_ready | req1_ready, 1'b0);
            step();
        end
        check1({tag, " rsp_valid@done"}, rsp0_valid | rsp1_valid, 1'b0);
        check1({tag, " busy@done"}, busy, 1'b0);
        model_last = exp_g;
    endtask

    typedef struct {
        bit          v0, v1;
        logic [2:0]  op0, op1;
        logic [15:0] a0, b0, a1, b1;
        int          delay;
        bit          exp_g;
        logic [15:0] exp_r;
        bit          exp_e;
    } vec_t;

    vec_t tbl[9];

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        tbl[0] = '{1, 0, 3'd0, 3'd0, 16'h000A, 16'h0002, 16'h0, 16'h0, 0, 0, 16'h000C, 0};
        tbl[1] = '{1, 1, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'h957C, 16'hDE63, 0, 1, 16'h56F4, 0};
        tbl[2] = '{1, 1, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'h957C, 16'hDE63, 0, 0, 16'hFFFF, 0};
        tbl[3] = '{1, 1, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'h957C, 16'hDE63, 0, 1, 16'h56F4, 0};
        tbl[4] = '{1, 1, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'h957C, 16'hDE63, 0, 0, 16'hFFFF, 0};
        tbl[5] = '{0, 1, 3'd0, 3'd3, 16'h0, 16'h0, 16'h1111, 16'hF13F, 5, 1, 16'h789F, 0};
        tbl[6] = '{1, 0, 3'd6, 3'd0, 16'h1234, 16'h5678, 16'h0, 16'h0, 0, 0, 16'h0000, 1};
        tbl[7] = '{1, 0, 3'd4, 3'd0, 16'h0003, 16'h65FA, 16'h0, 16'h0, 0, 0, 16'hCBF4, 0};
        tbl[8] = '{0, 1, 3'd0, 3'd5, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 1, 1, 16'h0000, 1};

        repeat (2) @(negedge clk);
        #1;
        check1("reset busy", busy, 1'b0);
        check1("reset rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        check16("reset alu_a", alu_a, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check16("reset rsp_result", rsp_result, 16'h0000);
        check1("reset rsp_err", rsp_err, 1'b0);
        check16("reset alu_op", 16'(alu_op), 16'h0000);
        check1("idle no-valid ready", req0_ready | req1_ready, 1'b0);
        model_last = 1'b1;

        for (int i = 0; i < 9; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1,
                tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1,
                tbl[i].delay, 1'b0, tbl[i].exp_g, tbl[i].exp_r, tbl[i].exp_e);
        end

        // Reset during EXEC aborts with no response; req0 wins the first tie afterwards.
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h0101; req1_b = 16'h0202;
        rsp1_ready = 1'b1;
        step();
        #1;
        check1("pre-abort busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("abort busy", busy, 1'b0);
        check1("abort rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        check16("abort alu_a", alu_a, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        check1("abort no rsp", rsp1_valid, 1'b0);
        model_last = 1'b1;
        txn("post-reset", 1'b1, 1'b1, 3'd0, 16'h0005, 16'h0006, 3'd1, 16'h0009, 16'h0001,
            0, 1'b0, 1'b0, 16'h000B, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit          v0, v1, g, drop;
            logic [2:0]  op0, op1;
            logic [15:0] a0, b0, a1, b1;
            logic [16:0] exp;
            int          d;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
            d = int'($urandom_range(0, 3));
            drop = 1'($urandom_range(0, 1));
            g = (v0 && v1) ? !model_last : v1;
            exp = g ? model_rsp(op1, a1, b1) : model_rsp(op0, a0, b0);
            txn($sformatf("rnd%0d", i), v0, v1, op0, a0, b0, op1, a1, b1,
                d, drop, g, exp[15:0], exp[16]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
